// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl
//   Four-key front panel controller for the DE2 digital clock.
//   Each key is synchronised and debounced, then classified as a short or
//   long press. The classified events drive the mode FSM (RUN, time adjust,
//   week adjust, alarm adjust), which emits one-cycle command pulses to the
//   time counter, the LCD week block and the alarm block. An inactivity
//   timeout forces the panel back to RUN.
//
// Ports
//   CLOCK_50      in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   KEY[3:0]      in   raw push buttons, low = pressed
//   mode[1:0]     out  0 RUN, 1 ADJ_TIME, 2 ADJ_WEEK, 3 ADJ_ALARM
//   adjust        out  0 only in ADJ_TIME
//   select        out  time digit select (wraps SEL_MAX -> 0)
//   add, clr      out  time digit +1 / clear pulses
//   add_week      out  LCD week +1 pulse
//   bl            out  LCD backlight toggle pulse
//   flip_state    out  alarm on/off toggle pulse
//   select_add, alarm_add, alarm_clr  out  alarm digit select / +1 / clear pulses
//   timeout_exit  out  pulse in the cycle mode returns to RUN by timeout
//
// Configuration macro
//   KEY_CTRL_AUTOREPEAT_EN : when defined, a K1 long press in ADJ_TIME or
//   ADJ_ALARM repeats add/alarm_add every REP_CYC cycles while held.

module key_mode_ctrl #(
  parameter int DEB_CYC     = 1_000_000,
  parameter int LONG_CYC    = 50_000_000,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int REP_CYC     = 10_000_000,
  parameter int SEL_W       = 4,
  parameter int SEL_MAX     = 15
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic [3:0]       KEY,
  output logic [1:0]       mode,
  output logic             adjust,
  output logic [SEL_W-1:0] select,
  output logic             add,
  output logic             clr,
  output logic             add_week,
  output logic             bl,
  output logic             flip_state,
  output logic             select_add,
  output logic             alarm_add,
  output logic             alarm_clr,
  output logic             timeout_exit
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    ADJ_TIME  = 2'd1,
    ADJ_WEEK  = 2'd2,
    ADJ_ALARM = 2'd3
  } mode_e;

  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int LONG_W = $clog2(LONG_CYC + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYC);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(SEL_MAX);

  // Key front end: synchroniser, debounced level, hold counters
  logic [3:0]        sync1_q, sync2_q;
  logic [3:0]        deb_q, deb_d, debPrev_q;
  logic [DEB_W-1:0]  debCnt_q  [4];
  logic [DEB_W-1:0]  debCnt_d  [4];
  logic [LONG_W-1:0] holdCnt_q [4];
  logic [LONG_W-1:0] holdCnt_d [4];

  logic [3:0] shortEv, longEv;
  logic       anyEdge;
  logic       repEv;
  logic       k1Long;

  // FSM and output registers
  mode_e             mode_q, mode_d;
  logic              adjust_q;
  logic [SEL_W-1:0]  select_q, select_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic add_q, add_d, clr_q, clr_d, addWeek_q, addWeek_d, bl_q, bl_d;
  logic flip_q, flip_d, selAdd_q, selAdd_d, alarmAdd_q, alarmAdd_d;
  logic alarmClr_q, alarmClr_d, timeout_q, timeout_d;

  // Winning event after priority resolution
  logic       evValid;
  logic [1:0] evKey;
  logic       evLong;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      deb_q     <= 4'hF;
      debPrev_q <= 4'hF;
      for (int k = 0; k < 4; k++) begin
        debCnt_q[k]  <= '0;
        holdCnt_q[k] <= '0;
      end
    end else begin
      sync1_q   <= KEY;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      debPrev_q <= deb_q;
      for (int k = 0; k < 4; k++) begin
        debCnt_q[k]  <= debCnt_d[k];
        holdCnt_q[k] <= holdCnt_d[k];
      end
    end
  end

  // The debounce counter tracks how long the synchronised key has disagreed
  // with the debounced level; any agreeing sample restarts it.
  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < 4; k++) begin
      debCnt_d[k]  = '0;
      holdCnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (debCnt_q[k] == DEB_LAST) begin
          deb_d[k] = sync2_q[k];
        end else begin
          debCnt_d[k] = debCnt_q[k] + 1'b1;
        end
      end
      if (!deb_q[k]) begin
        holdCnt_d[k] = (holdCnt_q[k] == LONG_MAX) ? holdCnt_q[k] : holdCnt_q[k] + 1'b1;
      end
    end
  end

  // On the release-edge cycle holdCnt_q still holds the press length, so a
  // saturated counter means the long event already fired for this press.
  always_comb begin
    anyEdge = |(debPrev_q ^ deb_q);
    for (int k = 0; k < 4; k++) begin
      longEv[k]  = !deb_q[k] && (holdCnt_q[k] == LONG_LAST);
      shortEv[k] = deb_q[k] && !debPrev_q[k] && (holdCnt_q[k] != LONG_MAX);
    end
  end

`ifdef KEY_CTRL_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REP_CYC + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYC - 1);

  logic [REP_W-1:0] repCnt_q, repCnt_d;
  logic             repArm_q, repArm_d;
  logic             k1Held;

  // Repeats are armed only by a long press taken in an adjust mode, so a K1
  // long that enters ADJ_ALARM from RUN does not start repeating there.
  always_comb begin
    k1Held   = !deb_q[1] && (holdCnt_q[1] == LONG_MAX);
    repEv    = k1Held && repArm_q && (repCnt_q == REP_LAST)
               && ((mode_q == ADJ_TIME) || (mode_q == ADJ_ALARM));
    repCnt_d = '0;
    if (k1Held) begin
      repCnt_d = (repCnt_q == REP_LAST) ? '0 : repCnt_q + 1'b1;
    end
    repArm_d = repArm_q && !deb_q[1];
    if (longEv[1] && ((mode_q == ADJ_TIME) || (mode_q == ADJ_ALARM))) begin
      repArm_d = 1'b1;
    end
    k1Long = longEv[1] || repEv;
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      repCnt_q <= '0;
      repArm_q <= 1'b0;
    end else begin
      repCnt_q <= repCnt_d;
      repArm_q <= repArm_d;
    end
  end
`else
  always_comb begin
    repEv  = 1'b0;
    k1Long = longEv[1];
  end
`endif

  // Same-cycle events resolve K3 > K0 > K1 > K2; the losers are dropped.
  always_comb begin
    evValid = 1'b1;
    evKey   = 2'd2;
    evLong  = 1'b0;
    if (shortEv[3] || longEv[3]) begin
      evKey  = 2'd3;
      evLong = longEv[3];
    end else if (shortEv[0] || longEv[0]) begin
      evKey  = 2'd0;
      evLong = longEv[0];
    end else if (shortEv[1] || k1Long) begin
      evKey  = 2'd1;
      evLong = k1Long;
    end else if (shortEv[2] || longEv[2]) begin
      evKey  = 2'd2;
      evLong = longEv[2];
    end else begin
      evValid = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= RUN;
      adjust_q   <= 1'b1;
      select_q   <= '0;
      idle_q     <= '0;
      add_q      <= 1'b0;
      clr_q      <= 1'b0;
      addWeek_q  <= 1'b0;
      bl_q       <= 1'b0;
      flip_q     <= 1'b0;
      selAdd_q   <= 1'b0;
      alarmAdd_q <= 1'b0;
      alarmClr_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      adjust_q   <= (mode_d != ADJ_TIME);
      select_q   <= select_d;
      idle_q     <= idle_d;
      add_q      <= add_d;
      clr_q      <= clr_d;
      addWeek_q  <= addWeek_d;
      bl_q       <= bl_d;
      flip_q     <= flip_d;
      selAdd_q   <= selAdd_d;
      alarmAdd_q <= alarmAdd_d;
      alarmClr_q <= alarmClr_d;
      timeout_q  <= timeout_d;
    end
  end

  // Timeout wins over a coincident event; a debounced edge or a repeat
  // counts as activity and blocks the timeout in that cycle.
  always_comb begin
    mode_d     = mode_q;
    select_d   = select_q;
    add_d      = 1'b0;
    clr_d      = 1'b0;
    addWeek_d  = 1'b0;
    bl_d       = 1'b0;
    flip_d     = 1'b0;
    selAdd_d   = 1'b0;
    alarmAdd_d = 1'b0;
    alarmClr_d = 1'b0;
    timeout_d  = 1'b0;

    if ((mode_q == RUN) || anyEdge || repEv) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end

    if ((mode_q != RUN) && (idle_q == IDLE_LAST) && !anyEdge && !repEv) begin
      mode_d    = RUN;
      timeout_d = 1'b1;
      idle_d    = '0;
    end else if (evValid) begin
      unique case (mode_q)
        RUN: begin
          if (evLong && evKey == 2'd3) begin
            mode_d   = ADJ_TIME;
            select_d = '0;
          end else if (evLong && evKey == 2'd0) begin
            mode_d = ADJ_WEEK;
          end else if (evLong && evKey == 2'd1) begin
            mode_d = ADJ_ALARM;
          end else if (!evLong && evKey == 2'd0) begin
            bl_d = 1'b1;
          end
        end
        ADJ_TIME: begin
          if (!evLong && evKey == 2'd3) begin
            mode_d = RUN;
          end else if (!evLong && evKey == 2'd0) begin
            select_d = (select_q == SEL_LAST) ? '0 : select_q + 1'b1;
          end else if (evKey == 2'd1) begin
`ifdef KEY_CTRL_AUTOREPEAT_EN
            add_d = 1'b1;
`else
            add_d = !evLong;
`endif
          end else if (!evLong && evKey == 2'd2) begin
            clr_d = 1'b1;
          end
        end
        ADJ_WEEK: begin
          if (!evLong && evKey == 2'd3) begin
            mode_d = RUN;
          end else if (!evLong && evKey == 2'd1) begin
            addWeek_d = 1'b1;
          end
        end
        ADJ_ALARM: begin
          if (!evLong && evKey == 2'd3) begin
            mode_d = RUN;
          end else if (evKey == 2'd0) begin
            flip_d   = evLong;
            selAdd_d = !evLong;
          end else if (evKey == 2'd1) begin
`ifdef KEY_CTRL_AUTOREPEAT_EN
            alarmAdd_d = 1'b1;
`else
            alarmAdd_d = !evLong;
`endif
          end else if (!evLong && evKey == 2'd2) begin
            alarmClr_d = 1'b1;
          end
        end
        default: mode_d = RUN;
      endcase
    end
  end

  assign mode         = mode_q;
  assign adjust       = adjust_q;
  assign select       = select_q;
  assign add          = add_q;
  assign clr          = clr_q;
  assign add_week     = addWeek_q;
  assign bl           = bl_q;
  assign flip_state   = flip_q;
  assign select_add   = selAdd_q;
  assign alarm_add    = alarmAdd_q;
  assign alarm_clr    = alarmClr_q;
  assign timeout_exit = timeout_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl
//   Directed bench for key_mode_ctrl with short simulation timing constants.
//   Pulse outputs are tallied in high cycles so that a stretched or stuck
//   pulse shows up as a wrong count.

module tb_key_mode_ctrl;

  localparam int DEB_CYC     = 4;
  localparam int LONG_CYC    = 40;
  localparam int TIMEOUT_CYC = 200;
  localparam int REP_CYC     = 10;
  localparam int SEL_W       = 4;
  localparam int SEL_MAX     = 5;

  logic             clk;
  logic             rst_n;
  logic [3:0]       KEY;
  logic [1:0]       mode;
  logic             adjust;
  logic [SEL_W-1:0] select;
  logic add, clr, add_week, bl, flip_state, select_add, alarm_add, alarm_clr, timeout_exit;

  int vectors     = 0;
  int miscompares = 0;

  int cycleNo = 0;
  int addHi = 0, clrHi = 0, addWeekHi = 0, blHi = 0, flipHi = 0;
  int selAddHi = 0, alarmAddHi = 0, alarmClrHi = 0, timeoutHi = 0;
  int addStamp[$];

  key_mode_ctrl #(
    .DEB_CYC(DEB_CYC), .LONG_CYC(LONG_CYC), .TIMEOUT_CYC(TIMEOUT_CYC),
    .REP_CYC(REP_CYC), .SEL_W(SEL_W), .SEL_MAX(SEL_MAX)
  ) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .KEY(KEY),
    .mode(mode), .adjust(adjust), .select(select),
    .add(add), .clr(clr), .add_week(add_week), .bl(bl),
    .flip_state(flip_state), .select_add(select_add),
    .alarm_add(alarm_add), .alarm_clr(alarm_clr),
    .timeout_exit(timeout_exit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  always @(negedge clk) begin
    if (add === 1'b1) begin
      addHi <= addHi + 1;
      addStamp.push_back(cycleNo);
    end
    if (clr === 1'b1)          clrHi      <= clrHi + 1;
    if (add_week === 1'b1)     addWeekHi  <= addWeekHi + 1;
    if (bl === 1'b1)           blHi       <= blHi + 1;
    if (flip_state === 1'b1)   flipHi     <= flipHi + 1;
    if (select_add === 1'b1)   selAddHi   <= selAddHi + 1;
    if (alarm_add === 1'b1)    alarmAddHi <= alarmAddHi + 1;
    if (alarm_clr === 1'b1)    alarmClrHi <= alarmClrHi + 1;
    if (timeout_exit === 1'b1) timeoutHi  <= timeoutHi + 1;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the given key pattern for 'cycles', release, then let the release
  // debounce and the resulting pulse settle.
  task automatic applyStimulus(input logic [3:0] keys, input int cycles);
    KEY = keys;
    waitCycles(cycles);
    KEY = 4'hF;
    waitCycles(12);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    int b, b2, b3, t0, s0;
    int expSel[7];
    expSel = '{1, 2, 3, 4, 5, 0, 1};

    KEY   = 4'hF;
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("reset_mode", mode, 0);
    checkOutput("reset_adjust", adjust, 1);
    checkOutput("reset_select", select, 0);
    checkOutput("reset_pulses",
                {add, clr, add_week, bl, flip_state, select_add, alarm_add, alarm_clr, timeout_exit}, 0);
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] glitch and backlight");
    b = blHi;
    KEY = 4'hE;
    waitCycles(3);
    KEY = 4'hF;
    waitCycles(15);
    checkOutput("glitch_no_bl", blHi - b, 0);
    b = blHi;
    applyStimulus(4'hE, 20);
    checkOutput("short_k0_bl", blHi - b, 1);
    checkOutput("short_k0_mode", mode, 0);
    b = blHi;
    applyStimulus(4'hE, 60);
    checkOutput("long_k0_mode", mode, 2);
    checkOutput("long_k0_no_bl", blHi - b, 0);
    b = addWeekHi;
    applyStimulus(4'hD, 20);
    checkOutput("week_add_week", addWeekHi - b, 1);
    applyStimulus(4'h7, 20);
    checkOutput("week_exit_mode", mode, 0);

    $display("[TB] time adjust");
    applyStimulus(4'h7, 60);
    checkOutput("adj_time_mode", mode, 1);
    checkOutput("adj_time_adjust", adjust, 0);
    checkOutput("adj_time_select0", select, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'hE, 20);
      checkOutput($sformatf("select_step%0d", i), select, expSel[i]);
    end
    b = addHi;
    applyStimulus(4'hD, 20);
    checkOutput("time_add", addHi - b, 1);
    b = clrHi;
    applyStimulus(4'hB, 20);
    checkOutput("time_clr", clrHi - b, 1);
`ifdef KEY_CTRL_AUTOREPEAT_EN
    b  = addHi;
    s0 = addStamp.size();
    applyStimulus(4'hD, 80);
    checkOutput("repeat_count", addHi - b, 5);
    if (addStamp.size() >= s0 + 5) begin
      for (int j = 0; j < 4; j++) begin
        checkOutput($sformatf("repeat_gap%0d", j), addStamp[s0 + j + 1] - addStamp[s0 + j], 10);
      end
    end
`else
    b = addHi;
    applyStimulus(4'hD, 60);
    checkOutput("k1_long_ignored", addHi - b, 0);
    checkOutput("k1_long_mode", mode, 1);
`endif
    applyStimulus(4'h7, 20);
    checkOutput("time_exit_mode", mode, 0);
    checkOutput("time_exit_adjust", adjust, 1);
    checkOutput("time_exit_select", select, 1);

    $display("[TB] alarm adjust");
    b = alarmAddHi;
    applyStimulus(4'hD, 60);
    checkOutput("adj_alarm_mode", mode, 3);
    checkOutput("adj_alarm_entry_no_add", alarmAddHi - b, 0);
    b  = flipHi;
    b2 = selAddHi;
    applyStimulus(4'hE, 60);
    checkOutput("alarm_flip", flipHi - b, 1);
    checkOutput("alarm_flip_no_seladd", selAddHi - b2, 0);
    b = selAddHi;
    applyStimulus(4'hE, 20);
    checkOutput("alarm_select_add", selAddHi - b, 1);
    b = alarmAddHi;
    applyStimulus(4'hD, 20);
    checkOutput("alarm_add", alarmAddHi - b, 1);
    b = alarmClrHi;
    applyStimulus(4'hB, 20);
    checkOutput("alarm_clr", alarmClrHi - b, 1);
    b  = selAddHi;
    b3 = blHi;
    applyStimulus(4'h6, 20);
    checkOutput("k0k3_mode", mode, 0);
    checkOutput("k0k3_no_seladd", selAddHi - b, 0);
    checkOutput("k0k3_no_bl", blHi - b3, 0);

    $display("[TB] inactivity timeout");
    applyStimulus(4'hE, 60);
    checkOutput("week_again_mode", mode, 2);
    t0 = timeoutHi;
    waitCycles(150);
    checkOutput("no_early_timeout", mode, 2);
    for (int i = 0; i < 100 && timeoutHi == t0; i++) waitCycles(1);
    waitCycles(3);
    checkOutput("timeout_pulse", timeoutHi - t0, 1);
    checkOutput("timeout_mode", mode, 0);
    checkOutput("timeout_adjust", adjust, 1);
    checkOutput("timeout_select_held", select, 1);

    $display("[TB] reset mid-press");
    applyStimulus(4'h7, 60);
    checkOutput("pre_reset_mode", mode, 1);
    KEY = 4'hE;
    waitCycles(30);
    rst_n = 1'b0;
    waitCycles(2);
    checkOutput("mid_reset_mode", mode, 0);
    checkOutput("mid_reset_adjust", adjust, 1);
    checkOutput("mid_reset_select", select, 0);
    checkOutput("mid_reset_pulses",
                {add, clr, add_week, bl, flip_state, select_add, alarm_add, alarm_clr, timeout_exit}, 0);
    rst_n = 1'b1;
    b = blHi;
    waitCycles(20);
    KEY = 4'hF;
    waitCycles(12);
    checkOutput("fresh_press_bl", blHi - b, 1);
    checkOutput("fresh_press_mode", mode, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
